// File: rtl/d_mem_responder.sv
// ---------------------------------------------------------------------------
// d_mem_responder
//   Data-memory responder for the MIPS core's load/store path. It accepts one
//   word read/write request at a time over a valid/ready handshake, waits
//   WAIT_CYCLES wait states, performs the access on an internal word array,
//   then holds the response until the requester accepts it. Use it in place
//   of the zero-latency d_mem when modelling slow memory.
//
//   Optional feature (compile-time macro DMEM_MISALIGN_CHECK_EN):
//     When defined, any request with addr[1:0] != 0 skips the array (stores
//     are dropped) and responds with rsp_err=1, rsp_rdata=0.
//     When undefined, addr[1:0] is ignored and rsp_err is always 0.
//
// Parameters
//   DEPTH        number of 32-bit words (power of two, >= 2)
//   WAIT_CYCLES  wait states between request accept and access (0..15)
//
// Ports
//   clock      in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   req_valid  in   request present
//   req_ready  out  responder can accept a request (IDLE, reset low)
//   req_we     in   1 = store word, 0 = load word
//   req_addr   in   byte address; word index is addr[log2(DEPTH)+1:2]
//   req_wdata  in   store data
//   rsp_valid  out  response present
//   rsp_ready  in   requester accepts the response
//   rsp_rdata  out  load data, or an echo of the stored word for stores
//   rsp_err    out  misaligned access flag
//   busy       out  high while waiting or holding a response
// ---------------------------------------------------------------------------
module d_mem_responder #(
   parameter int unsigned DEPTH       = 64,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        busy
);

   localparam int unsigned AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StResp
   } state_e;

   state_e         state_q, state_d;
   logic [3:0]     cnt_q, cnt_d;
   logic           we_q, we_d;
   logic [AW-1:0]  idx_q, idx_d;
   logic [31:0]    wdata_q, wdata_d;
   logic           mis_q, mis_d;
   logic [31:0]    rdata_q, rdata_d;
   logic           err_q, err_d;

   // Word array: deliberately not reset, contents survive reset.
   logic [31:0]    mem_q [DEPTH];

   logic           req_mis;
   logic           accept;
   logic           access;
   logic           mem_we;

   // Address bits that never select a word.
   logic           unused_addr;
   assign unused_addr = ^{req_addr[31:AW+2], req_addr[1:0]};

`ifdef DMEM_MISALIGN_CHECK_EN
   assign req_mis = |req_addr[1:0];
`else
   assign req_mis = 1'b0;
`endif

   // Internally, acceptance depends only on state; reset already holds the
   // state in IDLE, so the reset term is needed only on the visible port.
   assign accept = req_valid && (state_q == StIdle);
   assign access = (state_q == StWait) && (cnt_q == 4'd0);
   assign mem_we = access && we_q && !mis_q;

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      mis_d   = mis_q;
      rdata_d = rdata_q;
      err_d   = err_q;

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               we_d    = req_we;
               idx_d   = req_addr[AW+1:2];
               wdata_d = req_wdata;
               mis_d   = req_mis;
               cnt_d   = 4'(WAIT_CYCLES);
               state_d = StWait;
            end
         end

         StWait: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               state_d = StResp;
               if (mis_q) begin
                  rdata_d = 32'd0;
                  err_d   = 1'b1;
               end else if (we_q) begin
                  rdata_d = wdata_q;
                  err_d   = 1'b0;
               end else begin
                  rdata_d = mem_q[idx_q];
                  err_d   = 1'b0;
               end
            end
         end

         StResp: begin
            if (rsp_ready) begin
               state_d = StIdle;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         idx_q   <= '0;
         wdata_q <= 32'd0;
         mis_q   <= 1'b0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         mis_q   <= mis_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Commits only on the WAIT->RESP edge; a reset before then leaves state
   // in IDLE, so an interrupted store never lands.
   always_ff @(posedge clock) begin
      if (mem_we) begin
         mem_q[idx_q] <= wdata_q;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign req_ready = (state_q == StIdle) && !reset;
   assign rsp_valid = (state_q == StResp);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;
   assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_d_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_d_mem_responder
//   Self-checking bench for d_mem_responder. Two instances share the clock
//   and reset: dut index 0 uses WAIT_CYCLES=2, index 1 uses WAIT_CYCLES=0.
//   Directed vectors come from a table; random traffic is checked against a
//   word-array model of each memory.
// ---------------------------------------------------------------------------
module tb_d_mem_responder;

   localparam int unsigned DEPTH = 64;
`ifdef DMEM_MISALIGN_CHECK_EN
   localparam bit MisEn = 1'b1;
`else
   localparam bit MisEn = 1'b0;
`endif

   logic        clk;
   logic        reset;
   logic [1:0]  v;
   logic [1:0]  rr;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [1:0]  rdy, rv, er, bz;
   logic [31:0] rd [2];

   int checks = 0;
   int errors = 0;

   // Reference memories, one per instance.
   logic [31:0] mem_m   [2][DEPTH];
   bit          known_m [2][DEPTH];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   d_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(2)) dut_w2 (
      .clock     (clk),
      .reset     (reset),
      .req_valid (v[0]),
      .req_ready (rdy[0]),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rv[0]),
      .rsp_ready (rr[0]),
      .rsp_rdata (rd[0]),
      .rsp_err   (er[0]),
      .busy      (bz[0])
   );

   d_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut_w0 (
      .clock     (clk),
      .reset     (reset),
      .req_valid (v[1]),
      .req_ready (rdy[1]),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rv[1]),
      .rsp_ready (rr[1]),
      .rsp_rdata (rd[1]),
      .rsp_err   (er[1]),
      .busy      (bz[1])
   );

   typedef struct {
      int          s;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          hold;
      logic [31:0] exp_rd;
      bit          exp_err;
   } vec_t;

   vec_t vt[$];

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
      end
   endtask

   function automatic int wait_of(input int s);
      return (s == 0) ? 2 : 0;
   endfunction

   // One full transaction, starting and ending at a negedge with the DUT idle.
   task automatic txn(input int s, input bit w, input logic [31:0] a, input logic [31:0] d,
                      input int hold, input logic [31:0] exp_rd, input bit exp_err,
                      input bit chk_rd);
      int edges;
      int idx;
      chk("req_ready_before", {31'd0, rdy[s]}, 32'd1);
      req_we    = w;
      req_addr  = a;
      req_wdata = d;
      v[s]      = 1'b1;
      @(posedge clk);
      @(negedge clk);
      v[s]      = 1'b0;
      // Scramble the bus: the DUT must use its captured copy.
      req_we    = ~w;
      req_addr  = $urandom;
      req_wdata = $urandom;
      edges = 0;
      while (!rv[s] && edges < 40) begin
         @(posedge clk);
         @(negedge clk);
         edges++;
      end
      chk("latency", 32'(edges), 32'(wait_of(s) + 1));
      if (chk_rd) chk("rsp_rdata", rd[s], exp_rd);
      chk("rsp_err", {31'd0, er[s]}, {31'd0, exp_err});
      chk("busy_resp", {31'd0, bz[s]}, 32'd1);
      chk("req_ready_resp", {31'd0, rdy[s]}, 32'd0);
      for (int h = 0; h < hold; h++) begin
         @(posedge clk);
         @(negedge clk);
         chk("rsp_valid_hold", {31'd0, rv[s]}, 32'd1);
         if (chk_rd) chk("rsp_rdata_hold", rd[s], exp_rd);
         chk("req_ready_hold", {31'd0, rdy[s]}, 32'd0);
      end
      rr[s] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rr[s] = 1'b0;
      chk("rsp_valid_after", {31'd0, rv[s]}, 32'd0);
      chk("busy_after", {31'd0, bz[s]}, 32'd0);
      chk("req_ready_after", {31'd0, rdy[s]}, 32'd1);
      idx = int'((a >> 2) % DEPTH);
      if (w && !(MisEn && a[1:0] != 2'b00)) begin
         mem_m[s][idx]   = d;
         known_m[s][idx] = 1'b1;
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      for (int s = 0; s < 2; s++) begin
         chk({tag, "_req_ready"}, {31'd0, rdy[s]}, 32'd0);
         chk({tag, "_rsp_valid"}, {31'd0, rv[s]}, 32'd0);
         chk({tag, "_rsp_rdata"}, rd[s], 32'd0);
         chk({tag, "_rsp_err"}, {31'd0, er[s]}, 32'd0);
         chk({tag, "_busy"}, {31'd0, bz[s]}, 32'd0);
      end
   endtask

   initial begin
      int          s;
      bit          w;
      bit          mis;
      bit          chk_rd;
      int          idx;
      logic [31:0] a, d, exp_rd;

      reset     = 1'b1;
      v         = 2'b00;
      rr        = 2'b00;
      req_we    = 1'b0;
      req_addr  = 32'd0;
      req_wdata = 32'd0;
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < int'(DEPTH); j++) known_m[i][j] = 1'b0;

      repeat (2) @(negedge clk);
      chk_reset_outputs("reset");
      reset = 1'b0;
      @(negedge clk);
      chk("req_ready_out_of_reset0", {31'd0, rdy[0]}, 32'd1);
      chk("req_ready_out_of_reset1", {31'd0, rdy[1]}, 32'd1);

      // rsp_ready while idle must not disturb anything.
      rr = 2'b11;
      @(negedge clk);
      rr = 2'b00;
      chk("idle_rsp_ready_no_effect", {30'd0, rv}, 32'd0);

      vt.push_back('{0, 1'b1, 32'h10,  32'hDEADBEEF, 0, 32'hDEADBEEF, 1'b0});
      vt.push_back('{0, 1'b0, 32'h10,  32'h0,        0, 32'hDEADBEEF, 1'b0});
      vt.push_back('{0, 1'b1, 32'h0,   32'h12345678, 0, 32'h12345678, 1'b0});
      vt.push_back('{0, 1'b0, 32'h100, 32'h0,        0, 32'h12345678, 1'b0});
`ifdef DMEM_MISALIGN_CHECK_EN
      vt.push_back('{0, 1'b0, 32'h13,  32'h0,        0, 32'h0,        1'b1});
      vt.push_back('{0, 1'b1, 32'h13,  32'hCAFEF00D, 0, 32'h0,        1'b1});
      vt.push_back('{0, 1'b0, 32'h10,  32'h0,        0, 32'hDEADBEEF, 1'b0});
`else
      vt.push_back('{0, 1'b0, 32'h13,  32'h0,        0, 32'hDEADBEEF, 1'b0});
      vt.push_back('{0, 1'b1, 32'h13,  32'hCAFEF00D, 0, 32'hCAFEF00D, 1'b0});
      vt.push_back('{0, 1'b0, 32'h10,  32'h0,        0, 32'hCAFEF00D, 1'b0});
`endif
      vt.push_back('{0, 1'b0, 32'h0,   32'h0,        5, 32'h12345678, 1'b0});
      vt.push_back('{1, 1'b1, 32'h4,   32'h11112222, 0, 32'h11112222, 1'b0});
      vt.push_back('{1, 1'b0, 32'h4,   32'h0,        0, 32'h11112222, 1'b0});
      vt.push_back('{1, 1'b1, 32'h104, 32'h33334444, 0, 32'h33334444, 1'b0});
      vt.push_back('{1, 1'b0, 32'h4,   32'h0,        0, 32'h33334444, 1'b0});
      vt.push_back('{0, 1'b1, 32'h20,  32'hA5A5A5A5, 0, 32'hA5A5A5A5, 1'b0});

      foreach (vt[i]) begin
         txn(vt[i].s, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].hold, vt[i].exp_rd,
             vt[i].exp_err, 1'b1);
      end

      // Reset during WAIT aborts a pending store of 0 to 0x20.
      req_we    = 1'b1;
      req_addr  = 32'h20;
      req_wdata = 32'h0;
      v[0]      = 1'b1;
      @(posedge clk);
      @(negedge clk);
      v[0] = 1'b0;
      chk("abort_busy_in_wait", {31'd0, bz[0]}, 32'd1);
      @(posedge clk);
      #2 reset = 1'b1;
      #1 chk_reset_outputs("midreset");
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("req_ready_after_midreset", {31'd0, rdy[0]}, 32'd1);
      txn(0, 1'b0, 32'h20, 32'h0, 0, 32'hA5A5A5A5, 1'b0, 1'b1);

      // Random traffic against the model.
      for (int i = 0; i < 300; i++) begin
         s = int'($urandom_range(0, 1));
         w = 1'($urandom_range(0, 1));
         a = 32'($urandom_range(0, 1023));
         if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
         if ($urandom_range(0, 7) == 0) a[31:24] = 8'($urandom);
         d   = $urandom;
         mis = MisEn && (a[1:0] != 2'b00);
         idx = int'((a >> 2) % DEPTH);
         chk_rd = 1'b1;
         if (mis)      exp_rd = 32'd0;
         else if (w)   exp_rd = d;
         else begin
            exp_rd = mem_m[s][idx];
            chk_rd = known_m[s][idx];
         end
         txn(s, w, a, d, int'($urandom_range(0, 2)), exp_rd, mis, chk_rd);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
